// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// Holds the queue entry layout and the PC step.
package mips_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INCR      = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue with flush, push/pop, full/empty and count.
// Head data reads as zero while the queue is empty.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  fetch_entry_t             wdata_i,
    output fetch_entry_t             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int            PW     = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_C = (PW+1)'(DEPTH);
    localparam logic [PW:0]   ONE_C  = (PW+1)'(1);
    localparam logic [PW-1:0] ONE_P  = PW'(1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + ONE_P;
            if (pop_i)  rd_d = rd_q + ONE_P;
            unique case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + ONE_C;
                2'b01:   cnt_d = cnt_q - ONE_C;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_C);
    assign count_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem addressing, prefetch queue control.
// Redirects reload the PC and flush everything already fetched.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          QDEPTH   = 4,
    parameter int          AW       = 6
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_a,
    input  logic [31:0]   imem_rd,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_instr,
    output logic [31:0]   id_pc
);

    logic [31:0]  pc_q, pc_d;
    logic         deq, enq;
    logic         full, empty;
    logic [$clog2(QDEPTH):0] count;
    fetch_entry_t wr_entry, head;
    logic         unused_ok;

    assign deq = id_valid && id_ready;
    assign enq = !redirect && (!full || deq);

    always_comb begin
        pc_d = pc_q;
        if (redirect)  pc_d = {redirect_pc[31:2], 2'b00};
        else if (enq)  pc_d = pc_q + PC_INCR;
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    assign wr_entry = '{pc: pc_q, instr: imem_rd};

    // A handshake coincident with redirect is still consumed;
    // the flush wins over pop inside the queue.
    fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (enq),
        .pop_i   (deq),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign imem_a   = pc_q[AW+1:2];
    assign id_valid = !empty;
    assign id_instr = head.instr;
    assign id_pc    = head.pc;

    assign unused_ok = ^{redirect_pc[1:0], count};

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model plus directed pins.
// Random reset/redirect/ready traffic runs after the directed cases.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          QD     = 4;
    localparam int          AW     = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] imem_a;
    logic [31:0]   imem_rd;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          id_valid;
    logic          id_ready = 1'b0;
    logic [31:0]   id_instr;
    logic [31:0]   id_pc;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference: list of {pc, word} in fetch order, plus next fetch PC.
    logic [63:0] mq[$];
    logic [31:0] mpc = RST_PC;

    always #5 clk = ~clk;

    assign imem_rd = 32'h1000_0000 + 32'(imem_a);

    fetch_unit #(
        .RESET_PC (RST_PC),
        .QDEPTH   (QD),
        .AW       (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a >> 2) % (1 << AW);
        return 32'h1000_0000 + idx;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit rd,
                              input logic [31:0] rpc, input bit rdy);
        if (r) begin
            mq.delete();
            mpc = RST_PC;
        end else if (rd) begin
            mq.delete();
            mpc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (mq.size() < QD) begin
                mq.push_back({mpc, word_at(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit rd,
                       input logic [31:0] rpc, input bit rdy);
        reset       = r;
        redirect    = rd;
        redirect_pc = rpc;
        id_ready    = rdy;
        @(posedge clk);
        model_step(r, rd, rpc, rdy);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [63:0] hd;
            hd = (mq.size() > 0) ? mq[0] : 64'h0;
            check("valid", 32'(id_valid), 32'(mq.size() != 0));
            check("pc",    id_pc,    hd[63:32]);
            check("instr", id_instr, hd[31:0]);
            check("imem_a", 32'(imem_a), 32'((mpc >> 2) % (1 << AW)));
        end
    end

    initial begin
        @(negedge clk);
        cyc(1, 0, 0, 0);
        chk_en = 1'b1;
        check("rst_valid", 32'(id_valid), 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_imem_a", 32'(imem_a), 32'h0);

        // Streaming
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1);
            check("str_instr", id_instr, 32'h1000_0000 + 32'(i));
            check("str_pc", id_pc, 32'(4 * i));
        end

        // Backpressure and full pop/push
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        check("bp_imem_a", 32'(imem_a), 32'd4);
        check("bp_head", id_instr, 32'h1000_0000);
        cyc(0, 0, 0, 1);
        check("fp_imem_a", 32'(imem_a), 32'd5);
        check("fp_head", id_instr, 32'h1000_0001);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1);
            check("drain", id_instr, 32'h1000_0002 + 32'(i));
        end

        // Redirect with three entries queued
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h43, 0);
        check("rd_valid", 32'(id_valid), 32'h0);
        check("rd_imem_a", 32'(imem_a), 32'd16);
        cyc(0, 0, 0, 1);
        check("rd_pc", id_pc, 32'h40);
        check("rd_instr", id_instr, 32'h1000_0010);

        // Address wrap
        cyc(0, 1, 32'hFC, 1);
        cyc(0, 0, 0, 1);
        check("wr_pc", id_pc, 32'hFC);
        check("wr_instr", id_instr, 32'h1000_003F);
        check("wr_imem_a", 32'(imem_a), 32'd0);
        cyc(0, 0, 0, 1);
        check("wr_pc2", id_pc, 32'h100);
        check("wr_instr2", id_instr, 32'h1000_0000);

        // Back-to-back redirects: last wins
        cyc(0, 1, 32'h200, 1);
        cyc(0, 1, 32'h88, 1);
        cyc(0, 0, 0, 1);
        check("bb_pc", id_pc, 32'h88);

        // Reset mid-run with redirect
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
        cyc(1, 1, 32'h80, 1);
        check("mr_valid", 32'(id_valid), 32'h0);
        check("mr_pc", id_pc, 32'h0);
        check("mr_imem_a", 32'(imem_a), 32'h0);
        cyc(0, 0, 0, 1);
        check("mr_resume", id_instr, 32'h1000_0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, rd, rdy;
            r   = ($urandom_range(63) == 0);
            rd  = ($urandom_range(7) == 0);
            rdy = ($urandom_range(2) != 0);
            cyc(r, rd, $urandom, rdy);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the MIPS core. Owns the program counter, drives the word address of the combinational instruction memory, and buffers fetched words in a small prefetch queue. Hands instructions to decode through a valid/ready handshake. Accepts branch/jump redirects that flush the queue.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `QDEPTH`, default 4: prefetch queue entries; must be a power of two, at least 2.
- `AW`, default 6: instruction-memory word-address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_a` out AW: word address to instruction memory; equals `pc[AW+1:2]`.
- `imem_rd` in 32: instruction word returned combinationally for `imem_a` in the same cycle.
- `redirect` in 1: branch/jump taken; load `redirect_pc` and flush.
- `redirect_pc` in 32: redirect target byte address.
- `id_valid` out 1: queue head holds a valid instruction.
- `id_ready` in 1: decode accepts the head this cycle.
- `id_instr` out 32: head instruction word.
- `id_pc` out 32: byte address of the head instruction.

## Operation
- State: `pc` (32b), queue storage of {pc, instr}, read/write pointers (log2 QDEPTH bits, wrap modulo QDEPTH), and `count` (0..QDEPTH).
- Dequeue: `deq = id_valid && id_ready`.
- Enqueue: `enq = !redirect && (count < QDEPTH || deq)`. On enqueue, write {pc, imem_rd} and set `pc <= pc + 4`. When full, an enqueue in the same cycle as a dequeue is legal and `count` is unchanged.
- Stall: if `enq` = 0, `pc` holds and `imem_a` holds.
- Redirect, highest priority below reset:
  - `pc <= {redirect_pc[31:2], 2'b00}`, so misaligned low bits are discarded.
  - Pointers and `count` clear; no enqueue that cycle.
  - A coincident handshake counts as consumed by decode; the queue is still fully flushed.
- `id_valid = (count != 0)`. `id_instr` and `id_pc` are the head entry when valid and 0 when empty.
- Address wrap: `imem_a` is `pc[AW+1:2]` and wraps modulo 2^AW. `pc` itself wraps modulo 2^32.
- Reset: `pc = RESET_PC`, `count = 0`, pointers = 0. Outputs: `id_valid = 0`, `id_instr = 0`, `id_pc = 0`, `imem_a = RESET_PC[AW+1:2]`. Reset overrides redirect and handshake.

## Timing
- Fetch-to-valid latency is 1 cycle. A word addressed in cycle N is presented with `id_valid = 1` in cycle N+1 (queue empty, no redirect).
- Sustained throughput is 1 instruction/cycle with `id_ready` held high.
- First instruction after reset release: cycle 0 fetches `RESET_PC`; `id_valid` is 1 in cycle 1.
- Redirect asserted in cycle T:
  - `id_valid = 0` in T+1, while `imem_a` = target.
  - Target instruction is valid in T+2.
  - Back-to-back redirects: the last one wins.
- With `id_ready` low from an empty queue, the queue is full after QDEPTH cycles and `imem_a` freezes at index QDEPTH past the start.
- No combinational path from `id_ready` or `redirect` to `id_valid`, `id_instr` or `id_pc`. `imem_a` depends only on registered `pc`.

## Structure
- Shared package `mips_fetch_pkg`:
  - default `RESET_PC`;
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]};
  - constant `PC_INCR = 4`.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO with flush, push/pop, full/empty and count. `fetch_unit` contains the PC logic and the enqueue/redirect control.

## Test plan
- Streaming:
  - Stimulus: imem word i = 32'h1000_0000 + i; `id_ready` = 1; release reset.
  - Response: `id_valid` rises in cycle 1; `id_instr` = 10000000, 10000001, 10000002, … one per cycle with `id_pc` = 0, 4, 8, ….
- Backpressure:
  - Stimulus: `id_ready` = 0 for 10 cycles, then 1.
  - Response: `count` saturates at 4 and `imem_a` holds at 4; after release the outputs are words 0,1,2,3,4,5… in order, with no drop or duplicate.
- Full with simultaneous pop/push:
  - Stimulus: queue full, `id_ready` = 1 for one cycle.
  - Response: one instruction leaves, one enters, `count` stays 4, `imem_a` advances by 1.
- Redirect with queue holding 3 entries:
  - Stimulus: `redirect` = 1, `redirect_pc` = 32'h43.
  - Response: next cycle `id_valid` = 0 and `imem_a` = 16; the following cycle `id_pc` = 32'h40, `id_instr` = word 16.
- Wrap:
  - Stimulus: redirect to 32'hFC.
  - Response: `id_pc` = FC with word 63, then `id_pc` = 100 with `imem_a` = 0 and word 0.
- Reset mid-run:
  - Stimulus: full queue, assert `reset` for 1 cycle together with `redirect`.
  - Response: next cycle `id_valid` = 0, `id_pc` = 0, `imem_a` = 0; fetch resumes from `RESET_PC`.
